dff_bank_arbiter: RTL and testbench

//   Shares one W-bit register bank (synchronous-clear D flip-flops) among N requesters.

---
 rtl/dff_bank_arbiter_pkg.sv | 24 ++
 rtl/dff_bank_arbiter_rr_pick.sv | 37 +++
 rtl/dff_bank_arbiter.sv | 132 +++++++++++++
 tb/tb_dff_bank_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM state encoding and a
// constant-safe ceiling-log2 helper used to size index and counter fields.
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first active request at or
// after i_ptr, wrapping past N-1 back to 0.
module dff_bank_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] ptr, input int offset);
    return IW'((int'(ptr) + offset) % N);
  endfunction

  always_comb begin
    logic [IW-1:0] w_pos;
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_pos  = '0;
    // Scan from the farthest slot back so the nearest request overwrites last.
    for (int s = N - 1; s >= 0; s--) begin
      w_pos = slot(i_ptr, s);
      if (i_req[w_pos]) begin
        o_pick        = '0;
        o_pick[w_pos] = 1'b1;
        o_idx         = w_pos;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shares one W-bit synchronous-clear register among N requesters using
// round-robin grant, a load/ack handshake and an optional post-load hold window.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      data,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        ack,
  output logic [W-1:0]        q,
  output logic                busy,
  output logic [clog2(N)-1:0] owner
);

  localparam int IW  = clog2(N);
  localparam int HCW = (clog2(HOLD_CYCLES + 1) > 0) ? clog2(HOLD_CYCLES + 1) : 1;

  state_e         r_state;
  logic [N-1:0]   r_gnt;
  logic [N-1:0]   r_ack;
  logic [W-1:0]   r_q;
  logic           r_busy;
  logic [IW-1:0]  r_owner;
  logic [IW-1:0]  r_rr_ptr;
  logic [HCW-1:0] r_hold_cnt;

  logic [N-1:0]   w_pick;
  logic [IW-1:0]  w_pick_idx;
  logic           w_any;
  logic [IW-1:0]  w_owner_next;
  logic [W-1:0]   w_data_arr [N];

  dff_bank_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .i_req  (req),
    .i_ptr  (r_rr_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  for (genvar i = 0; i < N; i++) begin : g_data
    assign w_data_arr[i] = data[i*W +: W];
  end

  assign w_owner_next = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_q        <= '0;
      r_busy     <= 1'b0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else if (clr) begin
      // Abort whatever is in flight; fairness pointer and last owner survive.
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_q        <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_pick;
            r_owner <= w_pick_idx;
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          r_gnt <= '0;
          if (req[r_owner]) begin
            r_q      <= w_data_arr[r_owner];
            r_ack    <= r_gnt;
            r_rr_ptr <= w_owner_next;
            r_state  <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (HOLD_CYCLES > 0) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HCW'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Requests are ignored here; the counter tops out at HOLD_CYCLES.
          if (r_hold_cnt == HCW'(HOLD_CYCLES)) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign q     = r_q;
  assign busy  = r_busy;
  assign owner = r_owner;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: two arbiters (HOLD_CYCLES=2 and 0) run directed scenarios
// and random traffic against a transaction-phase reference model.
module tb_dff_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr_a, clr_b;
  logic [N-1:0]   req_a, req_b;
  logic [N*W-1:0] data_a, data_b;
  logic [N-1:0]   gnt_a, ack_a, gnt_b, ack_b;
  logic [W-1:0]   q_a, q_b;
  logic           busy_a, busy_b;
  logic [1:0]     owner_a, owner_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.N(N), .W(W), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .req(req_a), .data(data_a),
    .gnt(gnt_a), .ack(ack_a), .q(q_a), .busy(busy_a), .owner(owner_a)
  );

  dff_bank_arbiter #(.N(N), .W(W), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .req(req_b), .data(data_b),
    .gnt(gnt_b), .ack(ack_b), .q(q_b), .busy(busy_b), .owner(owner_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = free, 1 = granted, 2 = loaded, 3..2+H = holding.
  int             m_phase [2];
  int             m_owner [2];
  int             m_ptr   [2];
  logic [N-1:0]   m_gnt   [2];
  logic [N-1:0]   m_ack   [2];
  logic [W-1:0]   m_q     [2];

  function automatic void model_reset(input int k);
    m_phase[k] = 0;
    m_owner[k] = 0;
    m_ptr[k]   = 0;
    m_gnt[k]   = '0;
    m_ack[k]   = '0;
    m_q[k]     = '0;
  endfunction

  function automatic void model_step(input int k, input logic c, input logic [N-1:0] r,
                                     input logic [N*W-1:0] d);
    int h;
    h = (k == 0) ? 2 : 0;
    if (c) begin
      m_q[k]     = '0;
      m_phase[k] = 0;
      m_gnt[k]   = '0;
      m_ack[k]   = '0;
      return;
    end
    m_ack[k] = '0;
    if (m_phase[k] == 0) begin
      for (int s = 0; s < N; s++) begin
        int i;
        i = (m_ptr[k] + s) % N;
        if (r[i]) begin
          m_owner[k] = i;
          m_gnt[k]   = N'(1) << i;
          m_phase[k] = 1;
          break;
        end
      end
    end else if (m_phase[k] == 1) begin
      m_gnt[k] = '0;
      if (r[m_owner[k]]) begin
        m_q[k]     = d[m_owner[k]*W +: W];
        m_ack[k]   = N'(1) << m_owner[k];
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_phase[k] = 2;
      end else begin
        m_phase[k] = 0;
      end
    end else if (m_phase[k] < 2 + h) begin
      m_phase[k]++;
    end else begin
      m_phase[k] = 0;
    end
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic compare_all();
    check("a.q",     q_a,     m_q[0]);
    check("a.gnt",   gnt_a,   m_gnt[0]);
    check("a.ack",   ack_a,   m_ack[0]);
    check("a.busy",  busy_a,  m_phase[0] != 0);
    check("a.owner", owner_a, m_owner[0]);
    check("a.excl",  (gnt_a != 0) && (ack_a != 0), 1'b0);
    check("b.q",     q_b,     m_q[1]);
    check("b.gnt",   gnt_b,   m_gnt[1]);
    check("b.ack",   ack_b,   m_ack[1]);
    check("b.busy",  busy_b,  m_phase[1] != 0);
    check("b.owner", owner_b, m_owner[1]);
    check("b.excl",  (gnt_b != 0) && (ack_b != 0), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, clr_a, req_a, data_a);
    model_step(1, clr_b, req_b, data_b);
    @(negedge clk);
    compare_all();
  endtask

  // Requesters drop their line on ack; stop once everyone is served and idle.
  task automatic drain_a();
    for (int c = 0; c < 40; c++) begin
      tick();
      req_a = req_a & ~ack_a;
      if (req_a == 0 && !busy_a) break;
    end
    check("drain.busy", busy_a, 1'b0);
  endtask

  int idx;
  int busy_cnt;
  int n_ack;
  int got_order [4];
  int ack_cyc   [4];
  int ack_own   [4];

  initial begin
    rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    check("reset.q",     q_a,     8'h00);
    check("reset.gnt",   gnt_a,   4'b0000);
    check("reset.ack",   ack_a,   4'b0000);
    check("reset.busy",  busy_a,  1'b0);
    check("reset.owner", owner_a, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 2.
    req_a = 4'b0100; data_a = 32'h00A5_0000;
    busy_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      busy_cnt += int'(busy_a);
      if (c == 1) begin
        check("single.gnt",   gnt_a,   4'b0100);
        check("single.owner", owner_a, 2'd2);
      end
      if (c == 2) begin
        check("single.q",   q_a,   8'hA5);
        check("single.ack", ack_a, 4'b0100);
        req_a = '0;
      end
    end
    check("single.busy_cycles", busy_cnt, 4);

    // Asynchronous reset asserted mid-LOAD, observed before any clock edge.
    req_a = 4'b1000; data_a = 32'hC300_0000;
    tick();
    check("rstload.gnt", gnt_a, 4'b1000);
    tick();
    check("rstload.q_before", q_a, 8'hC3);
    #2 rst = 1'b1;
    #1;
    check("rstload.q",    q_a,    8'h00);
    check("rstload.gnt",  gnt_a,  4'b0000);
    check("rstload.ack",  ack_a,  4'b0000);
    check("rstload.busy", busy_a, 1'b0);
    model_reset(0);
    model_reset(1);
    req_a = '0;
    @(negedge clk);
    rst = 1'b0;

    // Round robin with all requesting; each drops on its own ack.
    for (int i = 0; i < 4; i++) got_order[i] = -1;
    req_a = 4'b1111; data_a = $urandom();
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      tick();
      idx = onehot_idx(ack_a);
      if (idx >= 0) begin
        got_order[n_ack] = idx;
        n_ack++;
        req_a[idx] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("rr.order%0d", i), got_order[i], i);
    req_a = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt_a != 0) break;
    end
    check("rr.wrap_gnt", gnt_a, 4'b0001);
    req_a = gnt_a;
    drain_a();

    // Load from requester 3 so the pointer returns to 0 with q = 5A.
    req_a = 4'b1000; data_a = 32'h5A00_0000;
    drain_a();
    check("wd.q_setup", q_a, 8'h5A);

    // Withdrawal during GRANT: no write, no ack, pointer not advanced.
    req_a = 4'b0010; data_a = 32'h0000_775A;
    tick();
    check("wd.gnt", gnt_a, 4'b0010);
    req_a = '0;
    tick();
    check("wd.gnt_after", gnt_a,  4'b0000);
    check("wd.ack",       ack_a,  4'b0000);
    check("wd.busy",      busy_a, 1'b0);
    check("wd.q",         q_a,    8'h5A);
    req_a = 4'b0011;
    tick();
    check("wd.regrant", gnt_a, 4'b0001);
    req_a = 4'b0001;
    drain_a();

    // clr coincident with the load edge wins.
    req_a = 4'b0001; data_a = 32'h0000_003C;
    tick();
    check("clrload.gnt", gnt_a, 4'b0001);
    clr_a = 1'b1;
    tick();
    check("clrload.q",    q_a,    8'h00);
    check("clrload.ack",  ack_a,  4'b0000);
    check("clrload.gnt",  gnt_a,  4'b0000);
    check("clrload.busy", busy_a, 1'b0);
    clr_a = 1'b0; req_a = '0;
    tick();

    // clr alone while idle.
    req_a = 4'b0001; data_a = 32'h0000_005A;
    drain_a();
    check("clridle.q_before", q_a, 8'h5A);
    clr_a = 1'b1;
    tick();
    check("clridle.q", q_a, 8'h00);
    clr_a = 1'b0;

    // Zero hold window: one load every third cycle, rotating owners.
    for (int i = 0; i < 4; i++) begin
      ack_cyc[i] = -1;
      ack_own[i] = -1;
    end
    req_b = 4'b1111; data_b = $urandom();
    n_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      idx = onehot_idx(ack_b);
      if (idx >= 0) begin
        if (n_ack < 4) begin
          ack_cyc[n_ack] = c;
          ack_own[n_ack] = idx;
        end
        n_ack++;
      end
    end
    check("h0.ack_count", n_ack, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("h0.owner%0d", i), ack_own[i], i);
      check($sformatf("h0.cycle%0d", i), ack_cyc[i], 2 + 3 * i);
    end
    req_b = '0;
    tick();

    // Random traffic on both instances against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_b = N'($urandom_range(0, 15));
      data_a = $urandom();
      data_b = $urandom();
      clr_a  = ($urandom_range(0, 24) == 0);
      clr_b  = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
